fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 142 ++++++++++++++
 tb/tb_fb_scanout.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: maps display coordinates onto a scrolled, double-buffered
// quarter-resolution framebuffer and returns pixels one cycle later.
module fb_scanout #(
   parameter int FB_W = 160,
   parameter int FB_H = 120
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   output logic [11:0] pixel,
   output logic [15:0] mem_addr,
   output logic        mem_en,
   input  logic [11:0] mem_rdata,
   input  logic [7:0]  scroll_x,
   input  logic [6:0]  scroll_y,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        front_page,
   output logic        vblank,
   output logic [15:0] frame_cnt
);

   localparam logic [15:0] FB_W_L   = 16'(FB_W);
   localparam logic [15:0] PAGE_OFS = 16'(FB_W * FB_H);
   localparam logic [9:0]  NO_PIX   = 10'h3FF;
   localparam logic [9:0]  LAST_ROW = 10'd479;

   typedef enum logic {IDLE, PENDING} swap_state_e;

   // Inputs are below 2*FB_W / 2*FB_H, so one subtract completes the modulo.
   function automatic logic [8:0] wrap_col(input logic [8:0] sum);
      return (sum >= 9'(FB_W)) ? sum - 9'(FB_W) : sum;
   endfunction

   function automatic logic [8:0] wrap_row(input logic [8:0] sum);
      return (sum >= 9'(FB_H)) ? sum - 9'(FB_H) : sum;
   endfunction

   function automatic logic [7:0] clamp_sx(input logic [7:0] s);
      return (s >= 8'(FB_W)) ? 8'd0 : s;
   endfunction

   function automatic logic [6:0] clamp_sy(input logic [6:0] s);
      return (s >= 7'(FB_H)) ? 7'd0 : s;
   endfunction

   // Shift-and-add over the set bits of FB_W (160 -> row<<7 + row<<5).
   function automatic logic [15:0] row_times_w(input logic [8:0] row);
      logic [15:0] acc;
      acc = 16'd0;
      for (int i = 0; i < 16; i++) begin
         if (FB_W_L[i]) acc = acc + (16'(row) << i);
      end
      return acc;
   endfunction

   logic        valid_d_q, valid_d_d;
   logic [9:0]  prev_y_q, prev_y_d;
   logic [7:0]  sx_q, sx_d;
   logic [6:0]  sy_q, sy_d;
   logic        front_page_q, front_page_d;
   logic        swap_ack_q, swap_ack_d;
   logic        vblank_q, vblank_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   swap_state_e state_q, state_d;

   logic        req_valid;
   logic        vblank_start;
   logic [8:0]  col_sum, row_sum, col, row;
   logic [15:0] addr;

   always_comb begin
      req_valid = (pix_x < 10'd640) && (pix_y < 10'd480);
      col_sum   = {1'b0, pix_x[9:2]} + {1'b0, sx_q};
      row_sum   = {1'b0, pix_y[9:2]} + {2'b0, sy_q};
      col       = wrap_col(col_sum);
      row       = wrap_row(row_sum);
      addr      = (front_page_q ? PAGE_OFS : 16'd0) + row_times_w(row) + {7'd0, col};
      mem_en    = req_valid;
      mem_addr  = req_valid ? addr : 16'd0;
      vblank_start = valid_d_q && (prev_y_q == LAST_ROW) && !req_valid && (pix_y == NO_PIX);
   end

   always_comb begin
      valid_d_d    = req_valid;
      prev_y_d     = pix_y;
      sx_d         = sx_q;
      sy_d         = sy_q;
      front_page_d = front_page_q;
      swap_ack_d   = 1'b0;
      vblank_d     = vblank_q;
      frame_cnt_d  = frame_cnt_q;
      state_d      = state_q;
      if (vblank_start) begin
         sx_d        = clamp_sx(scroll_x);
         sy_d        = clamp_sy(scroll_y);
         frame_cnt_d = frame_cnt_q + 16'd1;
         vblank_d    = 1'b1;
         // A request arriving on the vblank-start cycle itself still swaps now.
         if ((state_q == PENDING) || swap_req) begin
            front_page_d = ~front_page_q;
            swap_ack_d   = 1'b1;
         end
         state_d = IDLE;
      end else begin
         if (req_valid) vblank_d = 1'b0;
         if (swap_req) state_d = PENDING;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_d_q    <= 1'b0;
         prev_y_q     <= NO_PIX;
         sx_q         <= 8'd0;
         sy_q         <= 7'd0;
         front_page_q <= 1'b0;
         swap_ack_q   <= 1'b0;
         vblank_q     <= 1'b0;
         frame_cnt_q  <= 16'd0;
         state_q      <= IDLE;
      end else begin
         valid_d_q    <= valid_d_d;
         prev_y_q     <= prev_y_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         front_page_q <= front_page_d;
         swap_ack_q   <= swap_ack_d;
         vblank_q     <= vblank_d;
         frame_cnt_q  <= frame_cnt_d;
         state_q      <= state_d;
      end
   end

   assign pixel      = valid_d_q ? mem_rdata : 12'h000;
   assign swap_ack   = swap_ack_q;
   assign front_page = front_page_q;
   assign vblank     = vblank_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: RAM model, per-cycle behavioural model compare and
// directed scenarios with literal expectations.
module tb_fb_scanout;

   localparam int W = 160;
   localparam int H = 120;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [9:0]  pix_x = 10'h3FF;
   logic [9:0]  pix_y = 10'h3FF;
   logic [11:0] pixel;
   logic [15:0] mem_addr;
   logic        mem_en;
   logic [11:0] mem_rdata = 12'h000;
   logic [7:0]  scroll_x = 8'd0;
   logic [6:0]  scroll_y = 7'd0;
   logic        swap_req = 1'b0;
   logic        swap_ack;
   logic        front_page;
   logic        vblank;
   logic [15:0] frame_cnt;

   fb_scanout #(.FB_W(W), .FB_H(H)) dut (
      .clk(clk), .rstn(rstn), .pix_x(pix_x), .pix_y(pix_y), .pixel(pixel),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
      .scroll_x(scroll_x), .scroll_y(scroll_y), .swap_req(swap_req),
      .swap_ack(swap_ack), .front_page(front_page), .vblank(vblank),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   // Model state
   bit          m_page = 1'b0, m_pend = 1'b0, m_ack = 1'b0, m_vb = 1'b0, m_pv = 1'b0;
   int          m_sx = 0, m_sy = 0, m_py = 1023, m_pa = 0;
   logic [15:0] m_cnt = 16'd0;
   logic [15:0] preset_val = 16'd0;
   int          preset_seq = 0, preset_seen = 0;

   function automatic logic [11:0] h(input int a);
      logic [15:0] b;
      b = 16'(a);
      return b[11:0] ^ {b[15:12], 8'h5A};
   endfunction

   function automatic int exp_addr(input int x, input int y, input bit page, input int sx, input int sy);
      return (page ? W * H : 0) + ((y / 4 + sy) % H) * W + ((x / 4 + sx) % W);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Framebuffer RAM with one-cycle read latency; content is a hash of the address.
   always @(posedge clk) if (mem_en) mem_rdata <= h(int'(mem_addr));

   always @(posedge clk) begin
      bit v, vs;
      int a;
      if (preset_seq != preset_seen) begin
         m_cnt = preset_val;
         preset_seen = preset_seq;
      end
      v = (pix_x < 640) && (pix_y < 480);
      a = v ? exp_addr(int'(pix_x), int'(pix_y), m_page, m_sx, m_sy) : 0;
      if (!rstn) begin
         m_page = 0; m_pend = 0; m_ack = 0; m_vb = 0; m_pv = 0;
         m_sx = 0; m_sy = 0; m_py = 1023; m_pa = 0; m_cnt = 16'd0;
      end else begin
         vs = m_pv && (m_py == 479) && !v && (pix_y == 10'h3FF);
         m_ack = 0;
         if (vs) begin
            if (m_pend || swap_req) begin
               m_page = !m_page;
               m_ack = 1;
            end
            m_pend = 0;
            m_sx = (scroll_x >= W) ? 0 : int'(scroll_x);
            m_sy = (scroll_y >= H) ? 0 : int'(scroll_y);
            m_cnt = m_cnt + 16'd1;
            m_vb = 1;
         end else begin
            if (swap_req) m_pend = 1;
            if (v) m_vb = 0;
         end
         m_pv = v;
         m_py = int'(pix_y);
         m_pa = a;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         bit v;
         v = (pix_x < 640) && (pix_y < 480);
         check("mem_en", int'(mem_en), int'(v));
         check("mem_addr", int'(mem_addr),
               v ? exp_addr(int'(pix_x), int'(pix_y), m_page, m_sx, m_sy) : 0);
         check("pixel", int'(pixel), m_pv ? int'(h(m_pa)) : 0);
         check("front_page", int'(front_page), int'(m_page));
         check("swap_ack", int'(swap_ack), int'(m_ack));
         check("vblank", int'(vblank), int'(m_vb));
         check("frame_cnt", int'(frame_cnt), int'(m_cnt));
      end
   end

   task automatic step(input logic [9:0] x, input logic [9:0] y);
      @(posedge clk);
      #1;
      pix_x = x;
      pix_y = y;
   endtask

   task automatic frame_end(input logic sw);
      step(10'd639, 10'd479);
      step(10'h3FF, 10'h3FF);
      swap_req = sw;
      step(10'h3FF, 10'h3FF);
      swap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected bench completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);
      check("rst_front_page", int'(front_page), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      check("rst_vblank", int'(vblank), 0);
      check("rst_pixel", int'(pixel), 0);

      // Basic addressing and read latency
      step(10'd5, 10'd9);
      @(negedge clk);
      check("addr_5_9", int'(mem_addr), 321);
      check("en_5_9", int'(mem_en), 1);
      step(10'h3FF, 10'h3FF);
      @(negedge clk);
      check("pixel_321", int'(pixel), 12'h11B);
      check("invalid_en", int'(mem_en), 0);
      check("invalid_addr", int'(mem_addr), 0);
      step(10'h3FF, 10'h3FF);
      @(negedge clk);
      check("invalid_pixel", int'(pixel), 0);

      // Scroll wrap, latched only at vblank start
      scroll_x = 8'd150;
      scroll_y = 7'd115;
      frame_end(1'b0);
      @(negedge clk);
      check("frame_cnt_1", int'(frame_cnt), 1);
      check("vblank_set", int'(vblank), 1);
      scroll_x = 8'd3;
      scroll_y = 7'd5;
      step(10'd639, 10'd479);
      @(negedge clk);
      check("scroll_wrap", int'(mem_addr), 18389);
      step(10'd639, 10'd479);
      @(negedge clk);
      check("scroll_hold", int'(mem_addr), 18389);
      check("vblank_clr", int'(vblank), 0);

      // Out-of-range scroll clamps to zero
      scroll_x = 8'd200;
      scroll_y = 7'd120;
      frame_end(1'b0);
      step(10'd0, 10'd0);
      @(negedge clk);
      check("clamp_origin", int'(mem_addr), 0);
      step(10'd639, 10'd479);
      @(negedge clk);
      check("clamp_corner", int'(mem_addr), 19199);
      scroll_x = 8'd0;
      scroll_y = 7'd0;

      // Mid-frame swap request takes effect only at vblank start
      step(10'd4, 10'd4);
      swap_req = 1'b1;
      step(10'd8, 10'd8);
      swap_req = 1'b0;
      @(negedge clk);
      check("swap_hold", int'(front_page), 0);
      step(10'd639, 10'd479);
      step(10'h3FF, 10'h3FF);
      @(negedge clk);
      check("swap_vs_page", int'(front_page), 0);
      check("swap_vs_ack", int'(swap_ack), 0);
      step(10'h3FF, 10'h3FF);
      @(negedge clk);
      check("swap_page", int'(front_page), 1);
      check("swap_ack", int'(swap_ack), 1);
      step(10'd5, 10'd9);
      @(negedge clk);
      check("swap_ack_pulse", int'(swap_ack), 0);
      check("page1_addr", int'(mem_addr), 19521);

      // Request coinciding with vblank start
      frame_end(1'b1);
      @(negedge clk);
      check("swap_same_cycle", int'(front_page), 0);

      // Repeated requests collapse into one swap
      step(10'd1, 10'd1);
      swap_req = 1'b1;
      step(10'd2, 10'd2);
      swap_req = 1'b0;
      step(10'd3, 10'd3);
      swap_req = 1'b1;
      step(10'd4, 10'd4);
      swap_req = 1'b0;
      frame_end(1'b0);
      @(negedge clk);
      check("absorb_page", int'(front_page), 1);
      frame_end(1'b0);
      @(negedge clk);
      check("absorb_page2", int'(front_page), 1);
      check("absorb_ack", int'(swap_ack), 0);

      // Frame counter wrap, starting from a preset near the top
      step(10'h3FF, 10'h3FF);
      @(negedge clk);
      #1;
      dut.frame_cnt_q = 16'hFFFE;
      preset_val = 16'hFFFE;
      preset_seq++;
      frame_end(1'b0);
      @(negedge clk);
      check("cnt_ffff", int'(frame_cnt), 16'hFFFF);
      frame_end(1'b0);
      @(negedge clk);
      check("cnt_wrap", int'(frame_cnt), 0);

      // Reset while a swap is pending on page 1
      step(10'd10, 10'd10);
      swap_req = 1'b1;
      step(10'd11, 10'd11);
      swap_req = 1'b0;
      step(10'd12, 10'd12);
      rstn = 1'b0;
      step(10'h3FF, 10'h3FF);
      rstn = 1'b1;
      @(negedge clk);
      check("rst2_page", int'(front_page), 0);
      check("rst2_cnt", int'(frame_cnt), 0);
      frame_end(1'b0);
      @(negedge clk);
      check("rst2_no_swap", int'(front_page), 0);
      check("rst2_no_ack", int'(swap_ack), 0);
      step(10'd5, 10'd9);
      @(negedge clk);
      check("rst2_addr", int'(mem_addr), 321);
      step(10'h3FF, 10'h3FF);
      step(10'h3FF, 10'h3FF);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
